axi_wr_slave: RTL and testbench

//  AXI4 write-slave endpoint consuming the AW/W/B handshakes of the write-channel protocol FSM.
//  - Accepts one burst at a time.
//  - Generates per-beat byte addresses for FIXED/INCR/WRAP bursts and drives a simple memory write port.
//  - Returns one B response per burst.
//  - Sits directly downstream of the master-side AW/W/B FSM, in front of a RAM model.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_addr_next.sv | 31 +++
 rtl/axi_wr_slave.sv | 141 ++++++++++++++
 tb/tb_axi_wr_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 burst/response codes, slave state encoding
// and the 4KB page constant used by the write (and future read) slave.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [31:0] BOUNDARY_4K = 32'h1000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_RESP
   } state_t;

endpackage

// File: rtl/axi_addr_next.sv
// axi_addr_next: combinational next-beat byte address for
// FIXED/INCR/WRAP bursts.
module axi_addr_next #(
   parameter int AW = 32
) (
   input  logic [AW-1:0] cur,
   input  logic [2:0]    size,
   input  logic [7:0]    len,
   input  logic [1:0]    burst,
   output logic [AW-1:0] nxt
);
   import axi_pkg::*;

   logic [AW-1:0] incr;
   logic [AW-1:0] tot;

   always_comb begin
      incr = AW'(1) << size;
      tot  = (AW'(len) + AW'(1)) << size;
      nxt  = cur;
      unique case (burst)
         BURST_FIXED: nxt = cur;
         // Aligning first lets an unaligned start realign after beat 0
         BURST_INCR:  nxt = (cur & ~(incr - AW'(1))) + incr;
         BURST_WRAP:  nxt = (cur & ~(tot - AW'(1)))
                          | ((cur + incr) & (tot - AW'(1)));
         default:     nxt = cur;
      endcase
   end

endmodule

// File: rtl/axi_wr_slave.sv
// axi_wr_slave: AXI4 write-slave endpoint, one burst at a time,
// driving a single-beat memory write port and one B response per burst.
module axi_wr_slave #(
   parameter int AW = 32,
   parameter int DW = 64
) (
   input  logic            axi_aclk,
   input  logic            axi_aresetn,
   input  logic [AW-1:0]   s_awaddr,
   input  logic [7:0]      s_awlen,
   input  logic [2:0]      s_awsize,
   input  logic [1:0]      s_awburst,
   input  logic            s_awvalid,
   output logic            s_awready,
   input  logic [DW-1:0]   s_wdata,
   input  logic [DW/8-1:0] s_wstrb,
   input  logic            s_wlast,
   input  logic            s_wvalid,
   output logic            s_wready,
   output logic [1:0]      s_bresp,
   output logic            s_bvalid,
   input  logic            s_bready,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb
);
   import axi_pkg::*;

   localparam logic [2:0] MAXSZ = 3'($clog2(DW/8));

   state_t        state;
   logic [AW-1:0] cur;
   logic [AW-1:0] nxt;
   logic [7:0]    len_q;
   logic [7:0]    beat_cnt;
   logic [2:0]    size_q;
   logic [1:0]    burst_q;
   logic          err;

   logic [AW-1:0] size_mask;
   logic [31:0]   span;
   logic [31:0]   off;
   logic          len_ok;
   logic          aw_err;
   logic          cnt_end;
   logic          last_beat;
   logic          mismatch;

   axi_addr_next #(.AW(AW)) u_addr_next (
      .cur   (cur),
      .size  (size_q),
      .len   (len_q),
      .burst (burst_q),
      .nxt   (nxt)
   );

   always_comb begin
      size_mask = (AW'(1) << s_awsize) - AW'(1);
      span      = (32'(s_awlen) + 32'd1) << s_awsize;
      off       = 32'(s_awaddr[11:0]);
      len_ok    = (s_awlen == 8'd1) || (s_awlen == 8'd3)
               || (s_awlen == 8'd7) || (s_awlen == 8'd15);
      aw_err    = (s_awsize > MAXSZ)
               || (s_awburst == BURST_RSVD)
               || ((s_awburst == BURST_WRAP) && !len_ok)
               || ((s_awburst == BURST_WRAP)
                   && ((s_awaddr & size_mask) != '0))
               || ((s_awburst == BURST_INCR)
                   && ((off + span) > BOUNDARY_4K));
      cnt_end   = (beat_cnt == len_q);
      last_beat = s_wlast | cnt_end;
      mismatch  = s_wlast ^ cnt_end;
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state     <= ST_IDLE;
         cur       <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         err       <= 1'b0;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bresp   <= RESP_OKAY;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         mem_we <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (s_awready && s_awvalid) begin
                  cur       <= s_awaddr;
                  len_q     <= s_awlen;
                  size_q    <= s_awsize;
                  burst_q   <= s_awburst;
                  beat_cnt  <= '0;
                  err       <= aw_err;
                  s_awready <= 1'b0;
                  s_wready  <= 1'b1;
                  state     <= ST_DATA;
               end else begin
                  s_awready <= 1'b1;
               end
            end
            ST_DATA: begin
               if (s_wvalid && s_wready) begin
                  mem_we    <= ~err;
                  mem_addr  <= cur;
                  mem_wdata <= s_wdata;
                  mem_wstrb <= s_wstrb;
                  cur       <= nxt;
                  beat_cnt  <= beat_cnt + 8'd1;
                  if (last_beat) begin
                     err      <= err | mismatch;
                     s_wready <= 1'b0;
                     s_bvalid <= 1'b1;
                     s_bresp  <= (err | mismatch) ? RESP_SLVERR
                                                  : RESP_OKAY;
                     state    <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (s_bready) begin
                  s_bvalid  <= 1'b0;
                  s_awready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_slave.sv
// tb_axi_wr_slave: directed + randomized bursts against an
// arithmetic reference model of the AXI write slave.
module tb_axi_wr_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_awaddr = '0;
   logic [7:0]  s_awlen = '0;
   logic [2:0]  s_awsize = '0;
   logic [1:0]  s_awburst = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [63:0] s_wdata = '0;
   logic [7:0]  s_wstrb = '0;
   logic        s_wlast = 1'b0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b1;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;

   int checks = 0;
   int failures = 0;

   axi_wr_slave #(.AW(32), .DW(64)) dut (
      .axi_aclk    (clk),
      .axi_aresetn (rst_n),
      .s_awaddr    (s_awaddr),
      .s_awlen     (s_awlen),
      .s_awsize    (s_awsize),
      .s_awburst   (s_awburst),
      .s_awvalid   (s_awvalid),
      .s_awready   (s_awready),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .s_wlast     (s_wlast),
      .s_wvalid    (s_wvalid),
      .s_wready    (s_wready),
      .s_bresp     (s_bresp),
      .s_bvalid    (s_bvalid),
      .s_bready    (s_bready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_err(input longint unsigned a, input int len,
                                    input int size, input int burst);
      longint unsigned incr;
      bit pow2;
      incr = longint'(1) << size;
      pow2 = (len == 1) || (len == 3) || (len == 7) || (len == 15);
      if (size > 3) return 1;
      if (burst == 3) return 1;
      if (burst == 2 && !pow2) return 1;
      if (burst == 2 && (a % incr) != 0) return 1;
      if (burst == 1 && (a % 4096) + (len + 1) * incr > 4096) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] model_addr(input longint unsigned a,
      input int len, input int size, input int burst, input int i);
      longint unsigned incr, tot, lo;
      incr = longint'(1) << size;
      tot  = (len + 1) * incr;
      if (burst == 1) begin
         if (i == 0) return 32'(a);
         return 32'((a / incr) * incr + i * incr);
      end
      if (burst == 2) begin
         lo = (a / tot) * tot;
         return 32'(lo + ((a - lo + i * incr) % tot));
      end
      return 32'(a);
   endfunction

   // lpos: beat index carrying wlast (beyond len means never)
   task automatic run_burst(input logic [31:0] a, input int len,
                            input int size, input int burst,
                            input int lpos, input int bdly);
      bit aw_e;
      bit err;
      int nb;
      int waited;
      logic [63:0] d;
      logic [7:0] st;
      logic [1:0] eresp;
      aw_e  = model_err(a, len, size, burst);
      err   = aw_e || (lpos != len);
      nb    = ((lpos < len) ? lpos : len) + 1;
      eresp = err ? 2'b10 : 2'b00;
      waited = 0;
      while (!s_awready && waited < 20) begin
         cyc();
         waited++;
      end
      check("awready_idle", s_awready, 1);
      s_bready  = (bdly == 0);
      s_awaddr  = a;
      s_awlen   = 8'(len);
      s_awsize  = 3'(size);
      s_awburst = 2'(burst);
      s_awvalid = 1'b1;
      cyc();
      s_awvalid = 1'b0;
      check("aw_to_data", {s_awready, s_wready}, 2'b01);
      for (int i = 0; i < nb; i++) begin
         while ($urandom_range(0, 4) == 0) begin
            s_wvalid = 1'b0;
            cyc();
            check("idle_no_we", mem_we, 0);
         end
         d = {$urandom, $urandom};
         st = 8'($urandom);
         s_wdata  = d;
         s_wstrb  = st;
         s_wlast  = (i == lpos);
         s_wvalid = 1'b1;
         cyc();
         s_wvalid = 1'b0;
         s_wlast  = 1'b0;
         check("mem_we", mem_we, !aw_e);
         if (!aw_e) begin
            check("mem_addr", mem_addr, model_addr(a, len, size, burst, i));
            check("mem_wdata", mem_wdata, d);
            check("mem_wstrb", mem_wstrb, st);
         end
         if (i < nb - 1) check("wready_mid", s_wready, 1);
      end
      check("b_after_last", {s_wready, s_bvalid}, 2'b01);
      check("bresp", s_bresp, eresp);
      for (int j = 0; j < bdly; j++) begin
         cyc();
         check("b_hold", {s_awready, s_bvalid, s_bresp}, {2'b01, eresp});
         check("hold_no_we", mem_we, 0);
      end
      s_bready = 1'b1;
      cyc();
      check("b_done", {s_bvalid, s_awready}, 2'b01);
   endtask

   task automatic reset_mid_burst();
      s_awaddr  = 32'h2000;
      s_awlen   = 8'd7;
      s_awsize  = 3'd3;
      s_awburst = 2'b01;
      s_awvalid = 1'b1;
      cyc();
      s_awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_wdata  = {$urandom, $urandom};
         s_wstrb  = 8'hFF;
         s_wvalid = 1'b1;
         cyc();
      end
      check("pre_rst_we", mem_we, 1);
      #2;
      rst_n = 1'b0;
      s_wvalid = 1'b0;
      #1;
      check("rst_ctl", {s_awready, s_wready, s_bvalid, s_bresp, mem_we}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_wstrb", mem_wstrb, 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
      check("rel_awready0", s_awready, 0);
      cyc();
      check("rel_awready1", s_awready, 1);
   endtask

   initial begin
      logic [31:0] a;
      int sz, bu, ln, lp, bd, r;
      cyc();
      cyc();
      check("rst_ctl0", {s_awready, s_wready, s_bvalid, s_bresp, mem_we}, 0);
      check("rst_addr0", mem_addr, 0);
      rst_n = 1'b1;
      #1;
      check("awready_pre", s_awready, 0);
      cyc();
      check("awready_first", s_awready, 1);

      run_burst(32'h1000, 3, 3, 1, 3, 0);
      run_burst(32'h1010, 3, 3, 2, 3, 0);
      run_burst(32'h0020, 1, 2, 0, 1, 0);
      run_burst(32'h1003, 1, 2, 1, 1, 0);
      run_burst(32'h0FF8, 1, 3, 1, 1, 0);
      run_burst(32'h1000, 1, 4, 1, 1, 0);
      run_burst(32'h1000, 3, 3, 1, 1, 0);
      run_burst(32'h1000, 1, 3, 1, 300, 0);
      run_burst(32'h3000, 2, 3, 1, 2, 5);
      reset_mid_burst();
      run_burst(32'h4000, 3, 3, 1, 3, 0);

      for (int n = 0; n < 150; n++) begin
         r  = $urandom_range(0, 9);
         sz = (r == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
         r  = $urandom_range(0, 9);
         bu = (r < 3) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
         ln = $urandom_range(0, 15);
         if (bu == 2 && $urandom_range(0, 4) != 0)
            ln = (2 << $urandom_range(0, 3)) - 1;
         a = $urandom;
         if ($urandom_range(0, 2) == 0) a[11:4] = 8'hFF;
         if (bu == 2 && $urandom_range(0, 3) != 0)
            a = a & ~((32'd1 << sz) - 32'd1);
         r  = $urandom_range(0, 9);
         lp = ln;
         if (r >= 7 && r < 9 && ln > 0) lp = $urandom_range(0, ln - 1);
         if (r == 9) lp = 300;
         bd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
         run_burst(a, ln, sz, bu, lp, bd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout got=running want=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
